// File: rtl/zx_tape_pkg.sv
// Shared types and constants for the ZX80/ZX81 tape quick-load sequencer.
// Contents: FSM state enum, ROM trap addresses, RAM load bases and patch
// loop opcodes.
package zx_tape_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } tape_state_e;

  // ROM LOAD entry point and last address of the ROM load routine
  localparam logic [15:0] ENTRY_ZX81 = 16'h0347;
  localparam logic [15:0] ENTRY_ZX80 = 16'h0207;
  localparam logic [15:0] EXIT_ZX81  = 16'h03C2;
  localparam logic [15:0] EXIT_ZX80  = 16'h024C;

  // .o images load at the start of RAM, .p images skip the system vars
  localparam logic [15:0] BASE_O = 16'h4000;
  localparam logic [15:0] BASE_P = 16'h4009;

  // Patch loop: XOR A / (NOP|SCF) / JR NC,-3 / JP 02xx
  localparam logic [7:0] OP_XOR_A   = 8'hAF;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SCF     = 8'h37;
  localparam logic [7:0] OP_JR_NC   = 8'h30;
  localparam logic [7:0] OP_JR_DISP = 8'hFD;
  localparam logic [7:0] OP_JP      = 8'hC3;
  localparam logic [7:0] JP_LO_ZX81 = 8'h07;
  localparam logic [7:0] JP_LO_ZX80 = 8'h03;
  localparam logic [7:0] JP_HI      = 8'h02;
  localparam logic [7:0] OP_FILL    = 8'hFF;

  function automatic logic [15:0] entry_addr(input logic zx81);
    return zx81 ? ENTRY_ZX81 : ENTRY_ZX80;
  endfunction

  function automatic logic [15:0] exit_addr(input logic zx81);
    return zx81 ? EXIT_ZX81 : EXIT_ZX80;
  endfunction

endpackage

// File: rtl/zx_tape_patch_rom.sv
// Combinational patch loop ROM fed to the CPU while the trap window is live.
// Ports: off (addr - ENTRY), done (copy finished -> loop exits via SCF),
//        zx81 (ROM map select), patch_c (opcode byte for this offset).
module zx_tape_patch_rom
  import zx_tape_pkg::*;
(
  input  logic [15:0] off,
  input  logic        done,
  input  logic        zx81,
  output logic [7:0]  patch_c
);

  always_comb begin
    patch_c = OP_FILL;
    case (off)
      16'd0:   patch_c = OP_XOR_A;
      16'd1:   patch_c = done ? OP_SCF : OP_NOP;
      16'd2:   patch_c = OP_JR_NC;
      16'd3:   patch_c = OP_JR_DISP;
      16'd4:   patch_c = OP_JP;
      16'd5:   patch_c = zx81 ? JP_LO_ZX81 : JP_LO_ZX80;
      16'd6:   patch_c = JP_HI;
      default: patch_c = OP_FILL;
    endcase
  end

endmodule

// File: rtl/zx_tape_sequencer.sv
// Quick-load controller: traps the CPU at ROM LOAD, runs a patch loop and
// copies the downloaded tape image from the tape buffer into main RAM.
// Ports: clk_sys/reset (sync, active-high); zx81, ce_cpu_p, nM1, addr from
//        the CPU; dl_* from the HPS download port; buf_addr/buf_q to the tape
//        buffer (1 clk read latency); active/patch_data to the memory mux;
//        ram_we/ram_addr/ram_data to the RAM write mux; ready, led status.
// buf_addr and patch_data are combinational: the buffer prefetch must land
// in the same clk the counter advances, and the patch byte follows addr.
// Optional feature macro: TAPE_PROGRESS_EN (led blinks with copy progress).
module zx_tape_sequencer
  import zx_tape_pkg::*;
#(
  parameter int unsigned BUF_AW    = 14,
  parameter int unsigned LED_SHIFT = 10
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              zx81,
  input  logic              ce_cpu_p,
  input  logic              nM1,
  input  logic [15:0]       addr,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_index,
  input  logic [24:0]       dl_addr,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_q,
  output logic              active,
  output logic [7:0]        patch_data,
  output logic              ram_we,
  output logic [15:0]       ram_addr,
  output logic [7:0]        ram_data,
  output logic              ready,
  output logic              led
);

  localparam int unsigned LEN_W = BUF_AW + 1;

  tape_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [15:0]      base_q, base_d;
  logic             tape_p_q, tape_p_d;
  logic             ready_q, ready_d;
  logic             active_q, active_d;
  logic             ram_we_q, ram_we_d;
  logic [15:0]      ram_addr_q, ram_addr_d;
  logic [7:0]       ram_data_q, ram_data_d;
  logic             led_q, led_d;
  logic             nm1_q, dl_active_q;

  logic        m1_start, dl_rise, dl_fall, dl_tape;
  logic [15:0] entry, exit_end;

  assign m1_start = nm1_q & ~nM1;
  assign dl_rise  = dl_active & ~dl_active_q;
  assign dl_fall  = ~dl_active & dl_active_q;
  assign dl_tape  = (dl_index != 8'd0);
  assign entry    = entry_addr(zx81);
  assign exit_end = exit_addr(zx81);

  // Next-state, copy engine and download tracking
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    tape_p_d   = tape_p_q;
    ready_d    = ready_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;

    if (dl_wr && dl_tape) len_d = LEN_W'(dl_addr[BUF_AW-1:0]) + LEN_W'(1);
    if (dl_fall && dl_tape) begin
      ready_d  = 1'b1;
      tape_p_d = (dl_index[7:6] != 2'b00);
    end

    unique case (state_q)
      IDLE:  if (ready_q) state_d = ARMED;
      ARMED: begin
        if (m1_start && addr == entry) begin
          cnt_d   = '0;
          base_d  = tape_p_q ? BASE_P : BASE_O;
          state_d = FILL;
        end
      end
      FILL, DONE: begin
        if (m1_start && (addr < entry || addr > exit_end)) begin
          state_d = ARMED;
        end else if (m1_start && addr == entry) begin
          cnt_d   = '0;
          state_d = FILL;
        end else if (state_q == FILL) begin
          if (cnt_q < len_q) begin
            if (ce_cpu_p) begin
              ram_we_d   = 1'b1;
              ram_addr_d = base_q + 16'(cnt_q);
              ram_data_d = buf_q;
              cnt_d      = cnt_q + LEN_W'(1);
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new download discards whatever was loaded or in flight
    if (dl_rise) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      ram_we_d = 1'b0;
      cnt_d    = cnt_q;
    end

    active_d = (state_d == FILL) || (state_d == DONE);
`ifdef TAPE_PROGRESS_EN
    led_d = ready_d ^ ((state_d == FILL) && cnt_d[LED_SHIFT]);
`else
    led_d = dl_active | ready_d;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= BASE_O;
      tape_p_q    <= 1'b0;
      ready_q     <= 1'b0;
      active_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      led_q       <= 1'b0;
      nm1_q       <= 1'b1;
      dl_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      tape_p_q    <= tape_p_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      led_q       <= led_d;
      nm1_q       <= nM1;
      dl_active_q <= dl_active;
    end
  end

  // Prefetch: address the byte the counter will point at after this clk
  assign buf_addr = reset ? '0 : BUF_AW'(cnt_d);

  zx_tape_patch_rom u_patch_rom (
    .off     (addr - entry),
    .done    (state_q == DONE),
    .zx81    (zx81),
    .patch_c (patch_data)
  );

  assign active   = active_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ready    = ready_q;
  assign led      = led_q;

  // Download address bits above the buffer size are don't-care
  logic unused_ok;
  assign unused_ok = ^{dl_addr[24:BUF_AW], 1'(LED_SHIFT)};

endmodule

// File: tb/tb_zx_tape_sequencer.sv
// Directed self-checking bench for zx_tape_sequencer with a tape buffer
// model (registered read) and a RAM write log.
module tb_zx_tape_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        zx81 = 1'b1;
  logic        nM1 = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [7:0]  dl_index = 8'h00;
  logic [24:0] dl_addr = '0;
  logic [13:0] buf_addr;
  logic [7:0]  buf_q = 8'h00;
  logic        active, ram_we, ready, led;
  logic [7:0]  patch_data, ram_data;
  logic [15:0] ram_addr;

  logic        ce_man = 1'b0;
  int          ce_mode = 0;
  logic        ce_div = 1'b0;
  wire logic   ce_cpu_p = ce_man | (ce_mode == 1) | ((ce_mode == 2) & ce_div);

  logic [7:0]  buf_mem [0:16383];
  logic [15:0] wr_addr [$];
  logic [7:0]  wr_data [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    ce_div <= ~ce_div;
    buf_q  <= buf_mem[buf_addr];
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
    end
  end

  zx_tape_sequencer #(.BUF_AW(14), .LED_SHIFT(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .zx81       (zx81),
    .ce_cpu_p   (ce_cpu_p),
    .nM1        (nM1),
    .addr       (addr),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_index   (dl_index),
    .dl_addr    (dl_addr),
    .buf_addr   (buf_addr),
    .buf_q      (buf_q),
    .active     (active),
    .patch_data (patch_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ready      (ready),
    .led        (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed * 31 + i * 13 + (i >> 3));
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic download(input logic [7:0] idx, input int n, input int seed);
    dl_index  = idx;
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      buf_mem[i] = pat(seed, i);
      dl_addr    = 25'(i);
      dl_wr      = 1'b1;
      tick();
    end
    dl_wr     = 1'b0;
    tick();
    dl_active = 1'b0;
    tick();
    check("dl_ready", 32'(ready), 32'd1);
    check("dl_led", 32'(led), 32'd1);
    tick(2);
  endtask

  task automatic m1(input logic [15:0] a);
    addr = a;
    nM1  = 1'b0;
    tick();
    nM1  = 1'b1;
    tick();
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int c = 0; c < budget && wr_addr.size() < n; c++) tick();
    check("wr_timeout", 32'(wr_addr.size() >= n), 32'd1);
  endtask

  task automatic verify_writes(input logic [15:0] base, input int n, input int seed);
    check("wr_count", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(16'(base + 16'(i))));
      check($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(pat(seed, i)));
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) buf_mem[i] = 8'h00;
    tick(2);
    check("rst_active", 32'(active), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: .p image, 100 bytes, ZX81, CE every other clk
    zx81 = 1'b1;
    download(8'h41, 100, 1);
    clear_log();
    ce_mode = 2;
    m1(16'h0347);
    check("t1_active", 32'(active), 32'd1);
    addr = 16'h0348;
    #1;
    check("t1_patch_fill", 32'(patch_data), 32'h00);
    wait_writes(100, 1000);
    tick(4);
    check("t1_patch_done", 32'(patch_data), 32'h37);
    check("t1_active_done", 32'(active), 32'd1);
    verify_writes(16'h4009, 100, 1);
    m1(16'h0400);
    check("t1_exit_active", 32'(active), 32'd0);
    check("t1_exit_ready", 32'(ready), 32'd1);
    ce_mode = 0;

    // 2: .o image, 3 bytes, ZX80, back-to-back CE
    zx81 = 1'b0;
    download(8'h01, 3, 2);
    clear_log();
    ce_mode = 1;
    m1(16'h0207);
    wait_writes(3, 100);
    tick(3);
    verify_writes(16'h4000, 3, 2);
    addr = 16'h020C; #1;
    check("t2_patch_lo", 32'(patch_data), 32'h03);
    addr = 16'h0207; #1;
    check("t2_patch_0", 32'(patch_data), 32'hAF);
    addr = 16'h020E; #1;
    check("t2_patch_ff", 32'(patch_data), 32'hFF);
    m1(16'h024C);
    check("t2_exit_edge", 32'(active), 32'd1);
    m1(16'h024D);
    check("t2_exit_active", 32'(active), 32'd0);
    ce_mode = 0;

    // 3: CE held high, 200-byte .p image, exit below ENTRY
    zx81 = 1'b1;
    download(8'hC0, 200, 3);
    clear_log();
    ce_mode = 1;
    m1(16'h0347);
    wait_writes(200, 1000);
    tick(10);
    verify_writes(16'h4009, 200, 3);
    m1(16'h0346);
    check("t3_exit_low", 32'(active), 32'd0);
    ce_mode = 0;

    // 4: new download starts mid-FILL
    download(8'h01, 64, 4);
    clear_log();
    m1(16'h0347);
    for (int k = 0; k < 5; k++) begin
      ce_man = 1'b1; tick();
      ce_man = 1'b0; tick();
    end
    verify_writes(16'h4000, 5, 4);
    dl_active = 1'b1;
    tick();
    check("t4_active", 32'(active), 32'd0);
    check("t4_ready", 32'(ready), 32'd0);
`ifdef TAPE_PROGRESS_EN
    check("t4_led", 32'(led), 32'd0);
`else
    check("t4_led", 32'(led), 32'd1);
`endif
    n = wr_addr.size();
    ce_mode = 1;
    tick(10);
    check("t4_no_more_we", 32'(wr_addr.size()), 32'(n));
    ce_mode = 0;
    dl_active = 1'b0;
    tick(2);
    check("t4_ready_again", 32'(ready), 32'd1);

    // 5: reset, trap with nothing loaded, reset mid-FILL
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("t5_ready_clr", 32'(ready), 32'd0);
    clear_log();
    m1(16'h0347);
    tick(5);
    check("t5_no_trap", 32'(active), 32'd0);
    check("t5_no_writes", 32'(wr_addr.size()), 32'd0);
    download(8'h80, 32, 5);
    clear_log();
    ce_mode = 2;
    m1(16'h0347);
    tick(10);
    check("t5_filling", 32'(active), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_active", 32'(active), 32'd0);
    check("t5_rst_ram_we", 32'(ram_we), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd0);
    check("t5_rst_led", 32'(led), 32'd0);
    check("t5_rst_buf_addr", 32'(buf_addr), 32'd0);
    n = wr_addr.size();
    reset = 1'b0;
    tick(10);
    check("t5_post_rst_we", 32'(wr_addr.size()), 32'(n));
    check("t5_post_rst_active", 32'(active), 32'd0);
    ce_mode = 0;

`ifdef TAPE_PROGRESS_EN
    // 6: led follows copy progress every 4 bytes
    download(8'h01, 16, 6);
    clear_log();
    m1(16'h0347);
    check("t6_led_start", 32'(led), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ce_man = 1'b1; tick();
      ce_man = 1'b0;
      check($sformatf("t6_led[%0d]", k), 32'(led), 32'(1 ^ (((k + 1) >> 2) & 1)));
      tick();
    end
    tick(2);
    verify_writes(16'h4000, 16, 6);
    check("t6_led_done", 32'(led), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
